// File: rtl/cpu_pkg.sv
// Shared constants for the RV32I core pipeline.
// Field offsets and bubble/reset defaults used across stages.
package cpu_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0013;
    localparam int          RS1_LSB      = 15;
    localparam int          RS2_LSB      = 20;
    localparam int          REG_W        = 5;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clr (bubble insert) wins over en (advance).
// Holds PC, instruction word and valid flag of the instruction in decode.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int          XLEN      = cpu_pkg::XLEN,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            clr,
    input  logic [XLEN-1:0] d_pc,
    input  logic [31:0]     d_instr,
    output logic [XLEN-1:0] q_pc,
    output logic [31:0]     q_instr,
    output logic            q_valid
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q_pc    <= '0;
            q_instr <= NOP_INSTR;
            q_valid <= 1'b0;
        end else if (en) begin
            q_pc    <= d_pc;
            q_instr <= d_instr;
            q_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage: PC register, next-PC mux and IF/ID register.
// Define FETCH_PERF_EN to add stall/flush performance counters.
module if_id_stage
    import cpu_pkg::*;
#(
    parameter int          XLEN      = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic            id_valid,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;

    // Flush redirects even while stalled; the stalled load is already past ID.
    always_comb begin
        pc_next = pc;
        if (flush) begin
            pc_next = {branch_target[XLEN-1:2], 2'b00};
        end else if (!stall) begin
            pc_next = pc + PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    assign imem_addr = pc;

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .en      (~stall),
        .clr     (flush),
        .d_pc    (pc),
        .d_instr (imem_rdata),
        .q_pc    (id_pc),
        .q_instr (id_instr),
        .q_valid (id_valid)
    );

    assign id_rs1 = id_instr[RS1_LSB +: REG_W];
    assign id_rs2 = id_instr[RS2_LSB +: REG_W];

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (flush) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end else if (stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: stimulus pushes expected state,
// a negedge monitor pops and compares.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] id_pc;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   pushes = 0;
    int   pops = 0;
    logic [31:0] m_scnt = '0;
    logic [31:0] m_fcnt = '0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    // Instruction memory: address-derived words with distinct rs1/rs2 fields.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], 16'h5A33} ^ {a[7:0], 24'h0};
    endfunction

    assign imem_rdata = mem(imem_addr);

    if_id_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            pops++;
            chk("pc", imem_addr, e.pc);
            chk("id_pc", id_pc, e.id_pc);
            chk("id_instr", id_instr, e.instr);
            chk("id_valid", 32'(id_valid), 32'(e.valid));
            chk("id_rs1", 32'(id_rs1), 32'(e.instr[19:15]));
            chk("id_rs2", 32'(id_rs2), 32'(e.instr[24:20]));
`ifdef FETCH_PERF_EN
            chk("stall_cnt", perf_stall_cnt, e.scnt);
            chk("flush_cnt", perf_flush_cnt, e.fcnt);
`endif
        end
    end

    task automatic step(input logic rs, input logic st, input logic fl,
                        input logic [31:0] tgt, input logic [31:0] e_pc,
                        input logic [31:0] e_idpc, input logic [31:0] e_ins,
                        input logic e_v);
        exp_t e;
        @(negedge clk);
        #1;
        reset = rs;
        stall = st;
        flush = fl;
        branch_target = tgt;
        @(posedge clk);
        if (rs) begin
            m_scnt = '0;
            m_fcnt = '0;
        end else if (fl) begin
            m_fcnt = m_fcnt + 1;
        end else if (st) begin
            m_scnt = m_scnt + 1;
        end
        e.pc = e_pc;
        e.id_pc = e_idpc;
        e.instr = e_ins;
        e.valid = e_v;
        e.scnt = m_scnt;
        e.fcnt = m_fcnt;
        exp_q.push_back(e);
        pushes++;
    endtask

    initial begin
        // reset
        step(1, 0, 0, 0, 32'h0, 32'h0, NOP, 0);
        step(1, 0, 0, 0, 32'h0, 32'h0, NOP, 0);
        // free run
        step(0, 0, 0, 0, 32'h4, 32'h0, mem(32'h0), 1);
        step(0, 0, 0, 0, 32'h8, 32'h4, mem(32'h4), 1);
        // stall two cycles at pc=8
        step(0, 1, 0, 0, 32'h8, 32'h4, mem(32'h4), 1);
        step(0, 1, 0, 0, 32'h8, 32'h4, mem(32'h4), 1);
        step(0, 0, 0, 0, 32'hC, 32'h8, mem(32'h8), 1);
        step(0, 0, 0, 0, 32'h10, 32'hC, mem(32'hC), 1);
        // flush with misaligned target
        step(0, 0, 1, 32'h102, 32'h100, 32'h0, NOP, 0);
        step(0, 0, 0, 0, 32'h104, 32'h100, mem(32'h100), 1);
        // stall and flush together
        step(0, 1, 1, 32'h200, 32'h200, 32'h0, NOP, 0);
        step(0, 0, 0, 0, 32'h204, 32'h200, mem(32'h200), 1);
        step(0, 1, 0, 0, 32'h204, 32'h200, mem(32'h200), 1);
        // reset during stall at pc=40
        step(0, 0, 1, 32'h40, 32'h40, 32'h0, NOP, 0);
        step(0, 1, 0, 0, 32'h40, 32'h0, NOP, 0);
        step(1, 1, 0, 0, 32'h0, 32'h0, NOP, 0);
        step(0, 0, 0, 0, 32'h4, 32'h0, mem(32'h0), 1);
        // PC wrap
        step(0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, NOP, 0);
        step(0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 1);
        step(0, 0, 0, 0, 32'h4, 32'h0, mem(32'h0), 1);
        @(negedge clk);
        #2;
        chk("scoreboard_drain", 32'(pops), 32'(pushes));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
